// File: rtl/ram256x8_sync_pkg.sv
// Shared definitions for the byte-addressed big-endian data memory:
// opcodes, size field encodings, FSM states and load extension.
package ram256x8_sync_pkg;

  localparam logic [5:0] LOAD_W   = 6'b000000;
  localparam logic [5:0] LOAD_UB  = 6'b000001;
  localparam logic [5:0] LOAD_UHW = 6'b000010;
  localparam logic [5:0] LOAD_SB  = 6'b001001;
  localparam logic [5:0] LOAD_SHW = 6'b001010;
  localparam logic [5:0] STORE_W  = 6'b000100;
  localparam logic [5:0] STORE_B  = 6'b000101;
  localparam logic [5:0] STORE_HW = 6'b000110;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic op_valid(input logic [5:0] op);
    logic ok;
    case (op)
      LOAD_W, LOAD_UB, LOAD_UHW, LOAD_SB, LOAD_SHW,
      STORE_W, STORE_B, STORE_HW: ok = 1'b1;
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // word holds Mem[A..A+3] with Mem[A] in the top byte, so narrow loads take the top bits
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        sign);
    logic [31:0] res;
    case (size)
      SIZE_BYTE: res = sign ? {{24{word[31]}}, word[31:24]} : {24'd0, word[31:24]};
      SIZE_HALF: res = sign ? {{16{word[31]}}, word[31:16]} : {16'd0, word[31:16]};
      default:   res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ram256x8_sync.sv
// 256-byte big-endian data memory with multi-cycle access handshake (MFC).
// Accesses are latched in IDLE and performed after LATENCY cycles.
module ram256x8_sync
  import ram256x8_sync_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] DataOut,
  output logic        MFC,
  input  logic        Enable,
  input  logic [5:0]  OpCode,
  input  logic [7:0]  Address,
  input  logic [31:0] DataIn
);

  logic [7:0] Mem [0:255];

  state_t      state_r;
  logic [7:0]  count_r;
  logic [5:0]  op_r;
  logic [7:0]  addr_r;
  logic [31:0] din_r;

  logic [7:0]  a1_s, a2_s, a3_s;
  logic        fire_s, valid_s, wr_s, rd_s;
  logic [31:0] word_s, load_s;

  // Access decode; byte addresses wrap naturally in 8 bits
  always_comb begin
    a1_s    = addr_r + 8'd1;
    a2_s    = addr_r + 8'd2;
    a3_s    = addr_r + 8'd3;
    fire_s  = (state_r == ST_BUSY) && (count_r <= 8'd1);
    valid_s = op_valid(op_r);
    if (fire_s && valid_s) begin
      wr_s = op_r[2];
      rd_s = ~op_r[2];
    end else begin
      wr_s = 1'b0;
      rd_s = 1'b0;
    end
    word_s = {Mem[addr_r], Mem[a1_s], Mem[a2_s], Mem[a3_s]};
    load_s = load_extend(word_s, op_r[1:0], op_r[3]);
  end

  // Access sequencer with registered DataOut/MFC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      count_r <= 8'd0;
      op_r    <= 6'd0;
      addr_r  <= 8'd0;
      din_r   <= 32'd0;
      DataOut <= 32'd0;
      MFC     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          MFC <= 1'b0;
          if (Enable) begin
            op_r    <= OpCode;
            addr_r  <= Address;
            din_r   <= DataIn;
            count_r <= 8'(LATENCY - 1);
            state_r <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (fire_s) begin
            if (rd_s) begin
              DataOut <= load_s;
            end
            MFC     <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            count_r <= count_r - 8'd1;
          end
        end
        ST_DONE: begin
          MFC     <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          MFC     <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory array is not reset; an aborted access never reaches the write strobe
  always_ff @(posedge clk) begin
    if (wr_s) begin
      case (op_r[1:0])
        SIZE_WORD: begin
          Mem[addr_r] <= din_r[31:24];
          Mem[a1_s]   <= din_r[23:16];
          Mem[a2_s]   <= din_r[15:8];
          Mem[a3_s]   <= din_r[7:0];
        end
        SIZE_HALF: begin
          Mem[addr_r] <= din_r[15:8];
          Mem[a1_s]   <= din_r[7:0];
        end
        SIZE_BYTE: begin
          Mem[addr_r] <= din_r[7:0];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram256x8_sync.sv
// Scoreboard bench for ram256x8_sync: a byte-array reference model predicts
// each access result and MFC timing; a monitor checks every MFC pulse.
module tb_ram256x8_sync;
  import ram256x8_sync_pkg::*;

  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] DataOut;
  logic        MFC;
  logic        Enable = 1'b0;
  logic [5:0]  OpCode = 6'd0;
  logic [7:0]  Address = 8'd0;
  logic [31:0] DataIn = 32'd0;

  ram256x8_sync #(.LATENCY(LATENCY)) dut (
    .clk(clk), .reset_n(reset_n), .DataOut(DataOut), .MFC(MFC),
    .Enable(Enable), .OpCode(OpCode), .Address(Address), .DataIn(DataIn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          edge_no;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mem_m [256];
  logic [31:0] dout_m = 32'd0;
  int          edge_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          from_done = 1'b0;
  bit          mfc_prev = 1'b0;
  logic [5:0]  legal_ops [8] = '{LOAD_W, LOAD_UB, LOAD_UHW, LOAD_SB, LOAD_SHW,
                                 STORE_W, STORE_B, STORE_HW};

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory as a plain byte array, values built with arithmetic
  function automatic logic [31:0] model_op(input logic [5:0] op, input int addr,
                                           input logic [31:0] din);
    int     nb = 4;
    bit     st = 1'b0, sx = 1'b0, ok = 1'b1;
    longint v = 0;
    case (op)
      6'b000000: nb = 4;
      6'b000001: nb = 1;
      6'b000010: nb = 2;
      6'b001001: begin nb = 1; sx = 1'b1; end
      6'b001010: begin nb = 2; sx = 1'b1; end
      6'b000100: begin nb = 4; st = 1'b1; end
      6'b000101: begin nb = 1; st = 1'b1; end
      6'b000110: begin nb = 2; st = 1'b1; end
      default:   ok = 1'b0;
    endcase
    if (ok && st) begin
      for (int i = 0; i < nb; i++)
        mem_m[(addr + i) % 256] = 8'((din >> (8 * (nb - 1 - i))) & 32'hFF);
    end else if (ok) begin
      for (int i = 0; i < nb; i++)
        v = v * 256 + longint'(mem_m[(addr + i) % 256]);
      if (sx && v >= (64'sd1 <<< (8 * nb - 1))) v = v - (64'sd1 <<< (8 * nb));
      dout_m = 32'(v);
    end
    return dout_m;
  endfunction

  // Monitor: every MFC pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset_n) begin
      mfc_prev = 1'b0;
    end else begin
      if (MFC) begin
        if (mfc_prev) check("mfc_one_cycle", 32'd1, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_mfc", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_data"}, DataOut, e.data);
          check({e.name, "_mfc_edge"}, 32'(edge_cnt), 32'(e.edge_no));
        end
      end
      mfc_prev = MFC;
    end
  end

  // Issue one access at the current negedge and wait for its MFC
  task automatic issue(input logic [5:0] op, input logic [7:0] addr,
                       input logic [31:0] din, input string name);
    exp_t e;
    int   accept;
    bit   seen = 1'b0;
    OpCode  = op;
    Address = addr;
    DataIn  = din;
    Enable  = 1'b1;
    accept  = edge_cnt + (from_done ? 2 : 1);
    e.data    = model_op(op, int'(addr), din);
    e.edge_no = accept + LATENCY - 1;
    e.name    = name;
    exp_q.push_back(e);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (MFC) seen = 1'b1;
      else if (edge_cnt == accept) begin
        OpCode  = 6'($urandom);
        Address = 8'($urandom);
        DataIn  = $urandom;
        Enable  = 1'($urandom);
      end
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    from_done = 1'b1;
  endtask

  task automatic pause();
    Enable = 1'b0;
    repeat (2) @(negedge clk);
    from_done = 1'b0;
  endtask

  task automatic check_mem(input int lo, input int n, input string name);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_mem[%0d]", name, (lo + i) % 256),
            {24'd0, dut.Mem[(lo + i) % 256]}, {24'd0, mem_m[(lo + i) % 256]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    #2;
    check("reset_mfc", {31'd0, MFC}, 32'd0);
    check("reset_dout", DataOut, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 256; a += 4)
      issue(STORE_W, 8'(a), $urandom, "fill");
    pause();
    check_mem(0, 256, "fill");

    issue(STORE_W, 8'd0, 32'd234512, "sw_0");
    issue(STORE_B, 8'd4, 32'd5, "sb_4");
    issue(STORE_HW, 8'd8, 32'd1234, "sh_8");
    check_mem(0, 10, "st1");
    issue(LOAD_W, 8'd0, 32'd0, "lw_0");
    issue(LOAD_UB, 8'd4, 32'd0, "lub_4");
    issue(LOAD_SB, 8'd4, 32'd0, "lsb_4");
    issue(LOAD_UHW, 8'd8, 32'd0, "luh_8");
    issue(LOAD_SHW, 8'd8, 32'd0, "lsh_8");
    issue(STORE_B, 8'd4, 32'hFFFF_FFFB, "sb_m5");
    issue(LOAD_SB, 8'd4, 32'd0, "lsb_m5");
    issue(LOAD_UB, 8'd4, 32'd0, "lub_251");
    issue(STORE_HW, 8'd8, 32'hFFFF_F6CC, "sh_m2356");
    issue(LOAD_SHW, 8'd8, 32'd0, "lsh_m2356");
    issue(LOAD_UHW, 8'd8, 32'd0, "luh_63180");
    issue(STORE_W, 8'd254, 32'h1122_3344, "sw_wrap");
    issue(LOAD_W, 8'd255, 32'd0, "lw_wrap");
    issue(LOAD_SHW, 8'd255, 32'd0, "lsh_wrap");
    issue(6'b111111, 8'd0, 32'hFFFF_FFFF, "illegal_a");
    issue(6'b001000, 8'd1, 32'h0000_0000, "illegal_b");
    pause();
    check_mem(0, 12, "st2");
    check_mem(252, 4, "wrap");

    for (int r = 0; r < 80; r++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 7)];
      issue(op, 8'($urandom), $urandom, $sformatf("rnd%0d_op%02h", r, op));
    end
    issue(STORE_W, 8'd16, 32'hA5A5_A5A5, "pre_abort");
    issue(LOAD_W, 8'd0, 32'd0, "pre_abort_lw");
    pause();

    OpCode  = STORE_W;
    Address = 8'd16;
    DataIn  = 32'hDEAD_BEEF;
    Enable  = 1'b1;
    @(posedge clk);
    #2;
    Enable  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("abort_mfc", {31'd0, MFC}, 32'd0);
    check("abort_dout", DataOut, 32'd0);
    dout_m = 32'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    from_done = 1'b0;
    @(negedge clk);
    check("post_abort_mfc", {31'd0, MFC}, 32'd0);
    check_mem(16, 4, "abort");
    issue(LOAD_W, 8'd16, 32'd0, "lw_after_abort");
    pause();

    check_mem(0, 256, "final");
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
